rtc_timer_sched: RTL and testbench
==================================

Name: rtc_timer_sched

Overview:
Multi-channel software-timer scheduler driven by the RTC millisecond tick. It holds NUM_CH programmable countdown timers and services them with one shared decrementer, scanning one channel per clock after each tick. Each channel is one-shot or periodic. Expired channels raise pending flags, which are merged into a single prioritised interrupt for the CPU interrupt controller.

Parameters:
NUM_CH, 8, number of timer channels (2..16)
CH_W, $clog2(NUM_CH), channel index width (derived; not overridden)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
tick_i  input  1  1-cycle pulse per millisecond (RTC irq)
cfg_we_i  input  1  channel configuration write strobe
cfg_ch_i  input  CH_W  channel being configured
cfg_period_i  input  32  period in ms
cfg_periodic_i  input  1  1 = auto-reload, 0 = one-shot
cfg_en_i  input  1  arm (1) / disarm (0) the channel
ack_i  input  1  interrupt acknowledge strobe
ack_ch_i  input  CH_W  channel whose pending flag is cleared
irq_o  output  1  OR of all pending flags
irq_ch_o  output  CH_W  lowest-index pending channel; 0 when none pending
pending_o  output  NUM_CH  per-channel pending flags
active_o  output  NUM_CH  per-channel armed flags
busy_o  output  1  scan in progress
overrun_o  output  1  sticky tick-overrun flag

Behaviour:
- Per-channel state: period[31:0], remain[31:0], en, periodic, pending.
- Reset: all state, tick_pend, index and FSM cleared (state IDLE). All outputs 0.
- Config write, applied at the clock edge:
  - period <= cfg_period_i; remain <= cfg_period_i; periodic <= cfg_periodic_i; pending <= 0.
  - en <= cfg_en_i AND (cfg_period_i != 0). A period of 0 always disarms the channel.
- Tick capture: tick_i sets tick_pend. If tick_i is high while tick_pend is already 1, overrun_o <= 1. overrun_o is cleared only by reset.
- FSM states: IDLE, SCAN.
  - IDLE: if tick_pend, go to SCAN with idx <= 0 and tick_pend <= 0.
  - SCAN: process channel idx each cycle. If idx == NUM_CH-1, go to IDLE; otherwise idx <= idx+1.
- Channel processing when en = 1:
  - If remain == 1: pending <= 1. If periodic, remain <= period; otherwise en <= 0 and remain <= 0.
  - Otherwise: remain <= remain-1.
  - Channels with en = 0 are untouched.
- Latency: tick_i sampled at edge E0 sets tick_pend; SCAN is entered at E1; channel k is updated at edge E(2+k). pending_o is visible after that edge.
- One-shot of period P fires on the P-th tick after arming. Periodic fires on every P-th tick; P = 1 fires on every tick.
- A tick arriving during SCAN with tick_pend = 0 is queued. The next scan starts after the FSM passes through IDLE for one cycle; no tick is lost.
- Config write to the channel being scanned in the same cycle: the config result wins and the scan update is discarded.
- Ack clears the pending flag of ack_ch_i.
  - Ack in the same cycle that channel fires: set wins, pending stays 1.
  - Ack to a non-pending channel: no effect.
- Fire while already pending: pending stays 1 and no count is kept.
- irq_o, irq_ch_o, pending_o, active_o and busy_o are combinational from registers, with no extra latency. busy_o = (state == SCAN).

Test Plan:
- Reset, then arm ch2 one-shot period 3, send 3 ticks 100 cycles apart -> pending_o = 8'h04 after the 3rd scan reaches ch2, irq_o = 1, irq_ch_o = 2, active_o[2] = 0; ack ch2 -> irq_o = 0.
- Arm ch0 periodic period 1 and ch5 periodic period 2, send 4 ticks with ack after each -> ch0 fires 4 times, ch5 fires on ticks 2 and 4; irq_ch_o = 0 whenever both are pending.
- Write period 0 with cfg_en_i = 1 on ch1 -> active_o[1] = 0 and no fire after 10 ticks.
- Two tick_i pulses 3 cycles apart, second during SCAN -> both scans run back-to-back and overrun_o = 0. Three pulses inside one scan -> overrun_o = 1 and stays 1 until reset.
- Ack ch3 in the exact cycle ch3 expires -> pending_o[3] = 1. Config write to ch4 in its scan cycle -> remain = new period, pending_o[4] = 0.
- Assert rst_i mid-scan with channels pending -> all outputs 0 immediately; busy_o = 0; no fires after release until reprogrammed.

Source files
------------

// File: rtl/rtc_timer_sched.sv
// Multi-channel millisecond software-timer scheduler: one shared decrementer
// walks the channels after each RTC tick and raises prioritised pending flags.
module rtc_timer_sched #(
  parameter  int NUM_CH = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [31:0]       cfg_period_i,
  input  logic              cfg_periodic_i,
  input  logic              cfg_en_i,
  input  logic              ack_i,
  input  logic [CH_W-1:0]   ack_ch_i,
  output logic              irq_o,
  output logic [CH_W-1:0]   irq_ch_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] active_o,
  output logic              busy_o,
  output logic              overrun_o
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

  state_e            state_r;
  logic [CH_W-1:0]   idx_r;
  logic              tick_pend_r;
  logic              overrun_r;
  logic [31:0]       period_r [NUM_CH];
  logic [31:0]       remain_r [NUM_CH];
  logic [NUM_CH-1:0] en_r;
  logic [NUM_CH-1:0] periodic_r;
  logic [NUM_CH-1:0] pending_r;

  logic [NUM_CH-1:0] cfg_hit_s;
  logic [NUM_CH-1:0] scan_hit_s;
  logic [NUM_CH-1:0] fire_s;
  logic [NUM_CH-1:0] ack_hit_s;
  logic [CH_W-1:0]   irq_ch_s;

  // Per-channel decode of config, scan, expiry and acknowledge events
  always_comb begin
    cfg_hit_s  = {NUM_CH{1'b0}};
    scan_hit_s = {NUM_CH{1'b0}};
    fire_s     = {NUM_CH{1'b0}};
    ack_hit_s  = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_hit_s[i]  = cfg_we_i && (cfg_ch_i == CH_W'(i));
      scan_hit_s[i] = (state_r == SCAN) && (idx_r == CH_W'(i)) && en_r[i];
      fire_s[i]     = scan_hit_s[i] && (remain_r[i] == 32'd1);
      ack_hit_s[i]  = ack_i && (ack_ch_i == CH_W'(i));
    end
  end

  // Lowest-index pending channel wins; walk from the top so index 0 lands last
  always_comb begin
    irq_ch_s = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_r[i]) begin
        irq_ch_s = CH_W'(i);
      end else begin
        irq_ch_s = irq_ch_s;
      end
    end
  end

  // Scan sequencer and tick capture; a tick landing on the consuming cycle stays queued
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      idx_r       <= {CH_W{1'b0}};
      tick_pend_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (tick_i && tick_pend_r) begin
        overrun_r <= 1'b1;
      end
      tick_pend_r <= tick_i || (tick_pend_r && (state_r != IDLE));
      case (state_r)
        IDLE: begin
          if (tick_pend_r) begin
            state_r <= SCAN;
            idx_r   <= {CH_W{1'b0}};
          end
        end
        SCAN: begin
          if (idx_r == CH_W'(NUM_CH - 1)) begin
            state_r <= IDLE;
          end else begin
            idx_r <= idx_r + CH_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {CH_W{1'b0}};
        end
      endcase
    end
  end

  // Channel state: a config write overrides the scan update, and a fire beats an ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_r[i] <= 32'd0;
        remain_r[i] <= 32'd0;
      end
      en_r       <= {NUM_CH{1'b0}};
      periodic_r <= {NUM_CH{1'b0}};
      pending_r  <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_hit_s[i]) begin
          period_r[i]   <= cfg_period_i;
          remain_r[i]   <= cfg_period_i;
          periodic_r[i] <= cfg_periodic_i;
          en_r[i]       <= cfg_en_i && (cfg_period_i != 32'd0);
        end else if (fire_s[i]) begin
          if (periodic_r[i]) begin
            remain_r[i] <= period_r[i];
          end else begin
            remain_r[i] <= 32'd0;
            en_r[i]     <= 1'b0;
          end
        end else if (scan_hit_s[i]) begin
          remain_r[i] <= remain_r[i] - 32'd1;
        end

        if (cfg_hit_s[i]) begin
          pending_r[i] <= 1'b0;
        end else if (fire_s[i]) begin
          pending_r[i] <= 1'b1;
        end else if (ack_hit_s[i]) begin
          pending_r[i] <= 1'b0;
        end
      end
    end
  end

  assign irq_o     = |pending_r;
  assign irq_ch_o  = irq_ch_s;
  assign pending_o = pending_r;
  assign active_o  = en_r;
  assign busy_o    = (state_r == SCAN);
  assign overrun_o = overrun_r;

endmodule

// File: tb/tb_rtc_timer_sched.sv
// Scoreboard bench for rtc_timer_sched: expectations are queued as stimulus is
// applied and drained against the DUT outputs once each scan has settled.
module tb_rtc_timer_sched;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  logic              clk;
  logic              rst;
  logic              tick;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [31:0]       cfg_period;
  logic              cfg_periodic;
  logic              cfg_en;
  logic              ack;
  logic [CH_W-1:0]   ack_ch;
  logic              irq;
  logic [CH_W-1:0]   irq_ch;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] active;
  logic              busy;
  logic              overrun;

  typedef enum int {S_PEND, S_IRQ, S_IRQCH, S_ACT, S_BUSY, S_OVR} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   scan_cnt = 0;
  logic busy_q   = 1'b0;
  int   base;

  rtc_timer_sched #(.NUM_CH(NUM_CH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tick_i         (tick),
    .cfg_we_i       (cfg_we),
    .cfg_ch_i       (cfg_ch),
    .cfg_period_i   (cfg_period),
    .cfg_periodic_i (cfg_periodic),
    .cfg_en_i       (cfg_en),
    .ack_i          (ack),
    .ack_ch_i       (ack_ch),
    .irq_o          (irq),
    .irq_ch_o       (irq_ch),
    .pending_o      (pending),
    .active_o       (active),
    .busy_o         (busy),
    .overrun_o      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts scan starts as seen on the sampling edge
  always @(negedge clk) begin
    busy_q <= busy;
    if (busy && !busy_q) scan_cnt <= scan_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_PEND:  return 32'(pending);
      S_IRQ:   return 32'(irq);
      S_IRQCH: return 32'(irq_ch);
      S_ACT:   return 32'(active);
      S_BUSY:  return 32'(busy);
      S_OVR:   return 32'(overrun);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic cfg(input int ch, input logic [31:0] per, input logic periodic, input logic en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_period = per; cfg_periodic = periodic; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_ack(input int ch);
    @(negedge clk);
    ack = 1'b1; ack_ch = 3'(ch);
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (busy && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check_val("idle_timeout", 32'(cnt >= 50), 32'd0);
  endtask

  task automatic tick_scan();
    int cnt = 0;
    pulse_tick();
    while (!busy && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check_val("scan_start_timeout", 32'(cnt >= 10), 32'd0);
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_period = 32'd0;
    cfg_periodic = 1'b0; cfg_en = 1'b0; ack = 1'b0; ack_ch = 3'd0;
    repeat (3) @(negedge clk);
    push_exp("rst_pend", S_PEND, 32'd0);  push_exp("rst_irq", S_IRQ, 32'd0);
    push_exp("rst_irqch", S_IRQCH, 32'd0); push_exp("rst_act", S_ACT, 32'd0);
    push_exp("rst_busy", S_BUSY, 32'd0);  push_exp("rst_ovr", S_OVR, 32'd0);
    drain();
    rst = 1'b0;
    @(negedge clk);

    // One-shot period 3 on channel 2
    cfg(2, 32'd3, 1'b0, 1'b1);
    push_exp("t1_act_armed", S_ACT, 32'h04);
    drain();
    for (int t = 1; t <= 3; t++) begin
      tick_scan();
      repeat (85) @(negedge clk);
      if (t < 3) begin
        push_exp("t1_pend_early", S_PEND, 32'h00);
      end else begin
        push_exp("t1_pend", S_PEND, 32'h04);  push_exp("t1_irq", S_IRQ, 32'd1);
        push_exp("t1_irqch", S_IRQCH, 32'd2); push_exp("t1_act_done", S_ACT, 32'h00);
      end
      drain();
    end
    do_ack(2);
    push_exp("t1_irq_acked", S_IRQ, 32'd0);
    push_exp("t1_pend_acked", S_PEND, 32'h00);
    drain();

    // Periodic ch0 (P=1) and ch5 (P=2)
    cfg(0, 32'd1, 1'b1, 1'b1);
    cfg(5, 32'd2, 1'b1, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      tick_scan();
      push_exp("t2_pend", S_PEND, (t % 2 == 0) ? 32'h21 : 32'h01);
      push_exp("t2_irq", S_IRQ, 32'd1);
      push_exp("t2_irqch", S_IRQCH, 32'd0);
      drain();
      do_ack(0);
      do_ack(5);
      push_exp("t2_pend_acked", S_PEND, 32'h00);
      drain();
    end
    cfg(0, 32'd0, 1'b0, 1'b0);
    cfg(5, 32'd0, 1'b0, 1'b0);

    // Period 0 never arms
    cfg(1, 32'd0, 1'b0, 1'b1);
    push_exp("t3_act", S_ACT, 32'h00);
    drain();
    repeat (10) tick_scan();
    push_exp("t3_pend", S_PEND, 32'h00);
    push_exp("t3_irq", S_IRQ, 32'd0);
    drain();

    // Tick queued during a scan runs a second scan without overrun
    base = scan_cnt;
    pulse_tick();
    repeat (2) @(negedge clk);
    pulse_tick();
    repeat (30) @(negedge clk);
    check_val("t4_two_scans", 32'(scan_cnt - base), 32'd2);
    push_exp("t4_no_ovr", S_OVR, 32'd0);
    drain();

    // Third tick while one is already queued -> sticky overrun
    base = scan_cnt;
    pulse_tick();
    repeat (1) @(negedge clk);
    pulse_tick();
    pulse_tick();
    repeat (30) @(negedge clk);
    check_val("t4_merged_scans", 32'(scan_cnt - base), 32'd2);
    push_exp("t4_ovr", S_OVR, 32'd1);
    drain();
    tick_scan();
    repeat (20) @(negedge clk);
    push_exp("t4_ovr_sticky", S_OVR, 32'd1);
    drain();

    // Ack in the exact cycle ch3 expires: set wins
    cfg(3, 32'd1, 1'b0, 1'b1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    ack = 1'b1; ack_ch = 3'd3;
    @(negedge clk); ack = 1'b0;
    wait_idle();
    push_exp("t5_ack_race_pend", S_PEND, 32'h08);
    push_exp("t5_ack_race_act", S_ACT, 32'h00);
    drain();
    do_ack(3);
    push_exp("t5_ack_clear", S_PEND, 32'h00);
    drain();

    // Config write to ch4 in its scan cycle discards the scan update
    cfg(4, 32'd1, 1'b1, 1'b1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (5) @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 3'd4; cfg_period = 32'd5; cfg_periodic = 1'b0; cfg_en = 1'b1;
    @(negedge clk); cfg_we = 1'b0;
    wait_idle();
    push_exp("t5_cfg_race_pend", S_PEND, 32'h00);
    push_exp("t5_cfg_race_act", S_ACT, 32'h10);
    drain();
    for (int t = 1; t <= 5; t++) begin
      tick_scan();
      push_exp("t5_reload_pend", S_PEND, (t == 5) ? 32'h10 : 32'h00);
      drain();
    end
    push_exp("t5_reload_act", S_ACT, 32'h00);
    drain();

    // Reset in the middle of a scan with channels pending
    cfg(6, 32'd1, 1'b1, 1'b1);
    tick_scan();
    push_exp("t6_pre_pend", S_PEND, 32'h50);
    drain();
    pulse_tick();
    repeat (4) @(negedge clk);
    push_exp("t6_pre_busy", S_BUSY, 32'd1);
    drain();
    rst = 1'b1;
    #1;
    push_exp("t6_pend", S_PEND, 32'd0);  push_exp("t6_irq", S_IRQ, 32'd0);
    push_exp("t6_irqch", S_IRQCH, 32'd0); push_exp("t6_act", S_ACT, 32'd0);
    push_exp("t6_busy", S_BUSY, 32'd0);  push_exp("t6_ovr", S_OVR, 32'd0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick_scan();
    push_exp("t6_post_pend", S_PEND, 32'd0);
    push_exp("t6_post_act", S_ACT, 32'd0);
    push_exp("t6_post_irq", S_IRQ, 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
